// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes,
// ALU/PC select codes, FSM states and the per-state control decode.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FUNC_JR  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_RD    = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WR    = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_JR        = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11,
    ST_ADDI_EXEC = 4'd12,
    ST_ADDI_WB   = 4'd13
  } state_t;

  // Moore part of the control word; ir_write and the FETCH pc_write are
  // qualified by mem_ready in the top and are not part of this decode.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
      end
      ST_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALUOP_FUNC;
      end
      ST_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.alu_op    = ALUOP_FUNC;
      end
      ST_JR: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_REGA;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_REG;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      ST_ADDI_WB: begin
        c.reg_write = 1'b1;
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
interface mc_main_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       mem_timeout;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, mem_timeout, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, mem_timeout, state
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Counts consecutive not-ready cycles in a memory-wait state and flags
// expiry on the last allowed cycle. MEM_TIMEOUT = 0 never expires.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wait_state,
  input  logic i_mem_ready,
  output logic o_expire
);
  localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  logic [CNT_W-1:0] r_count;
  logic             w_expire;

  // Expire when the count sits on its last value and memory is still busy.
  always_comb begin
    w_expire = 1'b0;
    if ((MEM_TIMEOUT > 0) && i_wait_state && !i_mem_ready && (r_count == CNT_LAST)) begin
      w_expire = 1'b1;
    end else begin
      w_expire = 1'b0;
    end
  end

  // Any exit from the wait (ready, expiry, other state) restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!i_wait_state || i_mem_ready || w_expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expire = w_expire;
endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle MIPS datapath. Control outputs are
// registered decodes of the state being entered; only the FETCH
// ir_write/pc_write strobe follows mem_ready in the same cycle.
module mc_main_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  mc_main_ctrl_if.master bus
);
  state_t r_state;
  state_t w_next_state;
  ctrl_t  r_ctrl;
  logic   r_mem_timeout;
  logic   w_wait_state;
  logic   w_expire;
  logic   w_fetch_load;

  assign w_wait_state = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk          (clk),
    .rst          (rst),
    .i_wait_state (w_wait_state),
    .i_mem_ready  (bus.mem_ready),
    .o_expire     (w_expire)
  );

  // Next-state selection; a timeout abandons the access and refetches.
  always_comb begin
    w_next_state = r_state;
    if (w_expire) begin
      w_next_state = ST_FETCH;
    end else begin
      case (r_state)
        ST_RESET:  w_next_state = ST_FETCH;
        ST_FETCH: begin
          if (bus.mem_ready) w_next_state = ST_DECODE;
          else               w_next_state = ST_FETCH;
        end
        ST_DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW: w_next_state = ST_MEM_ADDR;
            OP_RTYPE:     w_next_state = ST_R_EXEC;
            OP_BEQ:       w_next_state = ST_BRANCH;
            OP_J:         w_next_state = ST_JUMP;
            OP_ADDI:      w_next_state = ST_ADDI_EXEC;
            default:      w_next_state = ST_FETCH;
          endcase
        end
        ST_MEM_ADDR: begin
          if (bus.opcode == OP_LW) w_next_state = ST_MEM_RD;
          else                     w_next_state = ST_MEM_WR;
        end
        ST_MEM_RD: begin
          if (bus.mem_ready) w_next_state = ST_MEM_WB;
          else               w_next_state = ST_MEM_RD;
        end
        ST_MEM_WR: begin
          if (bus.mem_ready) w_next_state = ST_FETCH;
          else               w_next_state = ST_MEM_WR;
        end
        ST_R_EXEC: begin
          if (bus.funct == FUNC_JR) w_next_state = ST_JR;
          else                      w_next_state = ST_R_WB;
        end
        ST_ADDI_EXEC: w_next_state = ST_ADDI_WB;
        default:      w_next_state = ST_FETCH;
      endcase
    end
  end

  // State register with the control word decoded for the incoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RESET;
      r_ctrl        <= CTRL_IDLE;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_ctrl        <= ctrl_decode(w_next_state);
      r_mem_timeout <= w_expire;
    end
  end

  assign w_fetch_load = (r_state == ST_FETCH) && bus.mem_ready;

  assign bus.pc_write      = r_ctrl.pc_write | w_fetch_load;
  assign bus.ir_write      = w_fetch_load;
  assign bus.pc_write_cond = r_ctrl.pc_write_cond;
  assign bus.i_or_d        = r_ctrl.i_or_d;
  assign bus.mem_read      = r_ctrl.mem_read;
  assign bus.mem_write     = r_ctrl.mem_write;
  assign bus.mem_to_reg    = r_ctrl.mem_to_reg;
  assign bus.reg_dst       = r_ctrl.reg_dst;
  assign bus.reg_write     = r_ctrl.reg_write;
  assign bus.alu_src_a     = r_ctrl.alu_src_a;
  assign bus.alu_src_b     = r_ctrl.alu_src_b;
  assign bus.alu_op        = r_ctrl.alu_op;
  assign bus.pc_source     = r_ctrl.pc_source;
  assign bus.mem_timeout   = r_mem_timeout;
  assign bus.state         = r_state;
endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench: an instruction-level model expands each instruction
// into per-cycle stimulus plus expected outputs; a driver and a monitor
// consume the two queues independently.
module tb_mc_main_ctrl;
  import mc_pkg::*;

  localparam int MEMT = 4;
  localparam logic [5:0] T_LW = 6'b100011, T_SW = 6'b101011, T_R = 6'b000000;
  localparam logic [5:0] T_BEQ = 6'b000100, T_J = 6'b000010, T_ADDI = 6'b001000;
  localparam logic [5:0] T_JRF = 6'b001000, T_ADDF = 6'b100000, T_ILL = 6'b111111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mc_main_ctrl_if bus();

  mc_main_ctrl #(.MEM_TIMEOUT(MEMT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, aop, psrc;
    logic tmo;
  } obs_t;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [5:0] opc;
    logic [5:0] fn;
    logic       z;
  } stim_t;

  typedef struct {
    obs_t  v;
    string tag;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int checks = 0;
  int failures = 0;

  logic [5:0] cur_opc = 6'd0;
  logic [5:0] cur_fn = 6'd0;
  bit pend_tmo = 1'b0;
  bit aborted = 1'b0;
  int istep = 0;
  int abort_step = -1;
  int instr_no = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected outputs of each step, straight from the control table.
  function automatic obs_t exp_vec(input state_t st, input logic rdy);
    obs_t v;
    v = '0;
    v.st = st;
    case (st)
      ST_FETCH:     begin v.mrd = 1'b1; v.asb = 2'b01; v.pcw = rdy; v.irw = rdy; end
      ST_DECODE:    begin v.asb = 2'b11; end
      ST_MEM_ADDR:  begin v.asa = 1'b1; v.asb = 2'b10; end
      ST_MEM_RD:    begin v.mrd = 1'b1; v.iord = 1'b1; end
      ST_MEM_WB:    begin v.rw = 1'b1; v.m2r = 1'b1; end
      ST_MEM_WR:    begin v.mwr = 1'b1; v.iord = 1'b1; end
      ST_R_EXEC:    begin v.asa = 1'b1; v.aop = 2'b10; end
      ST_R_WB:      begin v.rw = 1'b1; v.rdst = 1'b1; v.aop = 2'b10; end
      ST_JR:        begin v.pcw = 1'b1; v.psrc = 2'b11; end
      ST_BRANCH:    begin v.asa = 1'b1; v.aop = 2'b01; v.pcwc = 1'b1; v.psrc = 2'b01; end
      ST_JUMP:      begin v.pcw = 1'b1; v.psrc = 2'b10; end
      ST_ADDI_EXEC: begin v.asa = 1'b1; v.asb = 2'b10; end
      ST_ADDI_WB:   begin v.rw = 1'b1; end
      default:      begin end
    endcase
    return v;
  endfunction

  function automatic obs_t sample();
    obs_t v;
    v.st = bus.state; v.pcw = bus.pc_write; v.pcwc = bus.pc_write_cond;
    v.iord = bus.i_or_d; v.mrd = bus.mem_read; v.mwr = bus.mem_write;
    v.irw = bus.ir_write; v.m2r = bus.mem_to_reg; v.rdst = bus.reg_dst;
    v.rw = bus.reg_write; v.asa = bus.alu_src_a; v.asb = bus.alu_src_b;
    v.aop = bus.alu_op; v.psrc = bus.pc_source; v.tmo = bus.mem_timeout;
    return v;
  endfunction

  task automatic push(input logic r, input logic rdy, input state_t st);
    stim_t s;
    exp_t  e;
    s.rst = r; s.rdy = rdy; s.opc = cur_opc; s.fn = cur_fn; s.z = rb();
    e.v = exp_vec(st, rdy);
    e.v.tmo = pend_tmo && !r;
    pend_tmo = 1'b0;
    e.tag = $sformatf("i%0d_%s%s", instr_no, st.name(), r ? "_rst" : "");
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // One cycle of the instruction, or a reset pulse if this is the abort point.
  task automatic step(input logic rdy, input state_t st);
    if (istep == abort_step) begin
      push(1'b1, rb(), ST_RESET);
      push(1'b0, rb(), ST_RESET);
      aborted = 1'b1;
    end else begin
      push(1'b0, rdy, st);
    end
    istep++;
  endtask

  // Memory wait of del not-ready cycles (random if negative); too long a wait times out.
  task automatic mem_wait(input state_t st, input int del, output bit ok);
    int d;
    d = (del >= 0) ? del : int'($urandom_range(0, 6));
    ok = 1'b0;
    for (int i = 0; i < MEMT; i++) begin
      if (i == d) begin
        step(1'b1, st);
        ok = !aborted;
        return;
      end
      step(1'b0, st);
      if (aborted) return;
    end
    pend_tmo = 1'b1;
  endtask

  task automatic gen_instr(input logic [5:0] opc, input logic [5:0] fn,
                           input int fdel, input int mdel, input int abort_at);
    bit ok;
    cur_opc = opc; cur_fn = fn; aborted = 1'b0; istep = 0; abort_step = abort_at;
    instr_no++;
    mem_wait(ST_FETCH, fdel, ok);
    if (!ok) return;
    step(rb(), ST_DECODE);
    if (aborted) return;
    if (opc == T_LW || opc == T_SW) begin
      step(rb(), ST_MEM_ADDR);
      if (aborted) return;
      if (opc == T_LW) begin
        mem_wait(ST_MEM_RD, mdel, ok);
        if (!ok) return;
        step(rb(), ST_MEM_WB);
      end else begin
        mem_wait(ST_MEM_WR, mdel, ok);
      end
    end else if (opc == T_R) begin
      step(rb(), ST_R_EXEC);
      if (aborted) return;
      if (fn == T_JRF) step(rb(), ST_JR);
      else             step(rb(), ST_R_WB);
    end else if (opc == T_BEQ) begin
      step(rb(), ST_BRANCH);
    end else if (opc == T_J) begin
      step(rb(), ST_JUMP);
    end else if (opc == T_ADDI) begin
      step(rb(), ST_ADDI_EXEC);
      if (aborted) return;
      step(rb(), ST_ADDI_WB);
    end
  endtask

  initial begin
    int n;
    obs_t g;
    obs_t x;
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    // Reset held: state RESET, every output low.
    @(negedge clk);
    @(negedge clk);
    g = sample();
    x = exp_vec(ST_RESET, 1'b0);
    checks++;
    if (g !== x) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", g, x);
    end

    // First cycle after release is still RESET.
    push(1'b0, rb(), ST_RESET);

    gen_instr(T_LW,   6'd0,   0, 0, -1);
    gen_instr(T_R,    T_ADDF, 0, 0, -1);
    gen_instr(T_R,    T_JRF,  0, 0, -1);
    gen_instr(T_BEQ,  6'd0,   0, 0, -1);
    gen_instr(T_J,    6'd0,   1, 0, -1);
    gen_instr(T_ADDI, 6'd0,   3, 3, -1);
    gen_instr(T_LW,   6'd0,   2, 3, -1);
    gen_instr(T_SW,   6'd0,   0, 9, -1);
    gen_instr(T_ILL,  6'd0,   9, 0, -1);
    gen_instr(T_ILL,  6'd0,   0, 0, -1);
    gen_instr(T_LW,   6'd0,   0, 9,  4);
    gen_instr(T_SW,   6'd0,   0, 1, -1);
    for (int k = 0; k < 80; k++) begin
      logic [5:0] opc;
      logic [5:0] fn;
      int ab;
      case ($urandom_range(0, 6))
        0:       opc = T_LW;
        1:       opc = T_SW;
        2:       opc = T_R;
        3:       opc = T_BEQ;
        4:       opc = T_J;
        5:       opc = T_ADDI;
        default: opc = 6'($urandom);
      endcase
      fn = ($urandom_range(0, 3) == 0) ? T_JRF : 6'($urandom);
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
      gen_instr(opc, fn, -1, -1, ab);
    end
    gen_instr(T_ILL, 6'd0, 0, 0, -1);

    n = stim_q.size();
    fork
      begin
        for (int k = 0; k < n; k++) begin
          stim_t s;
          @(posedge clk);
          #1;
          s = stim_q.pop_front();
          rst = s.rst;
          bus.mem_ready = s.rdy;
          bus.opcode = s.opc;
          bus.funct = s.fn;
          bus.zero = s.z;
        end
      end
      begin
        for (int k = 0; k < n; k++) begin
          exp_t e;
          obs_t o;
          @(posedge clk);
          @(negedge clk);
          o = sample();
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty cyc=%0d got=%h exp=none", k, o);
          end else begin
            e = exp_q.pop_front();
            if (o !== e.v) begin
              failures++;
              $display("FAIL %s cyc=%0d got=%h exp=%h", e.tag, k, o, e.v);
            end
          end
          checks++;
          if (o.aop === 2'b11) begin
            failures++;
            $display("FAIL alu_op_11 cyc=%0d got=%b exp=not 11", k, o.aop);
          end
          checks++;
          if (o.pcw === 1'b1 && o.pcwc === 1'b1) begin
            failures++;
            $display("FAIL pc_write_both cyc=%0d got=11 exp=not both", k);
          end
        end
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
